i2c_codec_target: RTL and testbench
===================================

I2C_CODEC_TARGET -- requirements
Module: i2c_codec_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, 7-bit target address (write byte 0x34).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on SCLK/SDAT.
REQ-003 SHALL have port clk  input  1  system clock; the block uses this one clock only.
REQ-004 SHALL have port irstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SCLK  input  1  I2C clock from the initiator.
REQ-006 SHALL have port SDAT  inout  1  I2C data line, open-drain.
  - This block only drives it low (ACK); otherwise it is high-Z.
REQ-007 SHALL have port reg_addr  output  7  register address of the last committed write.
REQ-008 SHALL have port reg_data  output  9  register data of the last committed write.
REQ-009 SHALL have port wr_valid  output  1  one-clk pulse marking a committed write.
REQ-010 SHALL have port busy  output  1  high from START until STOP or abort.
REQ-011 SHALL have port rx_error  output  1  one-clk pulse on an aborted transaction.

Function
REQ-012 SHALL pass SCLK and SDAT through SYNC_STAGES flops, then detect edges on the synchronized values; all decisions use synchronized samples.
REQ-013 SHALL detect START as a synchronized SDAT fall while synchronized SCLK is high.
REQ-014 SHALL detect STOP as a synchronized SDAT rise while synchronized SCLK is high.
REQ-015 SHALL sample SDAT on the SCLK rising edge, MSB first, into an 8-bit shift register; a 3-bit bit counter advances once per bit.
REQ-016 SHALL implement FSM states IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP.
REQ-017 IDLE->ADDR on START; busy SHALL rise on the clk after START is detected.
REQ-018 After the 8th ADDR bit: if byte == {DEV_ADDR,1'b0}, SHALL go to ACK_A; otherwise SHALL go to IDLE, never drive SDAT, and pulse rx_error.
REQ-019 ACK drive: on the SCLK falling edge after the 8th bit of any byte in this transaction, SHALL pull SDAT low; SHALL release it on the next SCLK falling edge.
REQ-020 ACK_A->BYTE1->ACK_1->BYTE2->ACK_2->WAIT_STOP, each transition on the SCLK falling edge that ends that phase.
REQ-021 BYTE1 SHALL capture {addr[6:0], data[8]}; BYTE2 SHALL capture data[7:0] into holding registers.
REQ-022 WAIT_STOP+STOP: reg_addr/reg_data SHALL load from the holding registers, with a one-clk wr_valid pulse on the same clk; the FSM then returns to IDLE and busy falls.
REQ-023 STOP in any state other than IDLE/WAIT_STOP SHALL discard holding registers, pulse rx_error, release SDAT and go to IDLE; reg_addr/reg_data stay unchanged.
REQ-024 Repeated START in any non-IDLE state SHALL reset the bit counter, release SDAT and go to ADDR without a commit; rx_error pulses if not in WAIT_STOP.
REQ-025 Extra SCLK pulses in WAIT_STOP SHALL be ignored, with no ACK driven.
REQ-026 START and STOP SHALL take priority over data-bit sampling on the same clk.
REQ-027 Minimum supported SCLK high/low time SHALL be 4 clk periods; the target 2.5 kHz SCLK at a 50 MHz clk is well inside this.

Reset
REQ-028 irstn low SHALL asynchronously force: state IDLE, bit counter 0, shift/holding registers 0, SDAT released, reg_addr=0, reg_data=0, wr_valid=0, busy=0, rx_error=0.
REQ-029 Reset asserted mid-transaction SHALL release SDAT immediately with no commit; after release, the block waits for a new START.
REQ-030 Synchronizer flops SHALL reset to 1 (idle bus), so no false START occurs on reset release.

Structure
REQ-031 SHALL place the FSM state enumeration and default DEV_ADDR constant (7'h1A) in the shared codec I2C package.
REQ-032 SHALL use one sub-module, i2c_line_sync: synchronizer plus SCLK rise/fall and START/STOP strobes.

Verification
REQ-033 Bytes 0x34,0x1E,0x00 then STOP -> three ACK lows on SDAT; wr_valid one pulse; reg_addr=7'h0F, reg_data=9'h000.
REQ-034 Bytes 0x34,0x0D,0xFF then STOP -> wr_valid pulse; reg_addr=7'h06, reg_data=9'h1FF.
REQ-035 Address byte 0x36 -> SDAT never driven low; rx_error pulse; no wr_valid; outputs unchanged.
REQ-036 Bytes 0x34,0x08 then STOP -> rx_error pulse, no wr_valid; next full 0x34,0x08,0x12 -> reg_addr=7'h04, reg_data=9'h012.
REQ-037 Repeated START after byte 0x34, then 0x34,0x1E,0x05 STOP -> a single wr_valid; reg_addr=7'h0F, reg_data=9'h005.
REQ-038 irstn asserted during BYTE2 ACK low -> SDAT goes high-Z within the same clk; all outputs 0; busy 0.

Source files
------------

// File: rtl/i2c_codec_target_pkg.sv
// Shared definitions for the I2C codec register-write target.
package i2c_codec_target_pkg;

  localparam logic [6:0]  DEV_ADDR_DEFAULT    = 7'h1A;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned ADDR_W              = 7;
  localparam int unsigned DATA_W              = 9;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned CNT_W               = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    BYTE1,
    ACK_1,
    BYTE2,
    ACK_2,
    WAIT_STOP
  } state_e;

  // Register write carried by one transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_payload_t;

  // Address byte a write to this device must present.
  function automatic logic [BYTE_W-1:0] addr_write_byte(input logic [ADDR_W-1:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_codec_target_line_sync.sv
// Synchronizes SCLK/SDAT into clk and produces registered edge and bus-condition strobes.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_rise_q;
  logic                   scl_fall_q;
  logic                   start_q;
  logic                   stop_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chains and edge strobes; everything resets to the idle-high bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      scl_rise_q <= scl_s & ~scl_prev_q;
      scl_fall_q <= ~scl_s & scl_prev_q;
      start_q    <= scl_s & scl_prev_q & ~sda_s & sda_prev_q;
      stop_q     <= scl_s & scl_prev_q & sda_s & ~sda_prev_q;
    end
  end

  // sda_prev_q holds the sample the strobes were computed from.
  assign sda_o      = sda_prev_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_codec_target.sv
// I2C write-only target: address byte plus two data bytes form a 7-bit register / 9-bit data write.
module i2c_codec_target
  import i2c_codec_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       irstn,
  input  logic       SCLK,
  inout  wire        SDAT,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       wr_valid,
  output logic       busy,
  output logic       rx_error
);

  logic sda_s;
  logic scl_rise_s;
  logic scl_fall_s;
  logic start_s;
  logic stop_s;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [BYTE_W-1:0] shift_q,    shift_d;
  logic              full_q,     full_d;
  wr_payload_t       hold_q,     hold_d;
  wr_payload_t       reg_q,      reg_d;
  logic              ack_q,      ack_d;
  logic              wr_valid_q, wr_valid_d;
  logic              busy_q,     busy_d;
  logic              rx_error_q, rx_error_d;
  logic [BYTE_W-1:0] byte_nx;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst_n     (irstn),
    .scl_i     (SCLK),
    .sda_i     (SDAT),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise_s),
    .scl_fall_o(scl_fall_s),
    .start_o   (start_s),
    .stop_o    (stop_s)
  );

  // Open-drain: only ever pull low during an ACK slot.
  assign SDAT = ack_q ? 1'b0 : 1'bz;

  assign reg_addr = reg_q.addr;
  assign reg_data = reg_q.data;
  assign wr_valid = wr_valid_q;
  assign busy     = busy_q;
  assign rx_error = rx_error_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge irstn) begin
    if (!irstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      full_q     <= 1'b0;
      hold_q     <= '0;
      reg_q      <= '0;
      ack_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      full_q     <= full_d;
      hold_q     <= hold_d;
      reg_q      <= reg_d;
      ack_q      <= ack_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      rx_error_q <= rx_error_d;
    end
  end

  // Next state: bus conditions first, then bit sampling on SCLK rise and phase steps on SCLK fall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    full_d     = full_q;
    hold_d     = hold_q;
    reg_d      = reg_q;
    ack_d      = ack_q;
    wr_valid_d = 1'b0;
    rx_error_d = 1'b0;
    byte_nx    = {shift_q[BYTE_W-2:0], sda_s};

    if (start_s) begin
      // START or repeated START: restart address phase, no commit.
      if (state_q != IDLE && state_q != WAIT_STOP) begin
        rx_error_d = 1'b1;
      end
      state_d = ADDR;
      cnt_d   = '0;
      full_d  = 1'b0;
      ack_d   = 1'b0;
      hold_d  = '0;
    end else if (stop_s) begin
      if (state_q == WAIT_STOP) begin
        reg_d      = hold_q;
        wr_valid_d = 1'b1;
      end else if (state_q != IDLE) begin
        hold_d     = '0;
        rx_error_d = 1'b1;
      end
      state_d = IDLE;
      cnt_d   = '0;
      full_d  = 1'b0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, BYTE1, BYTE2: begin
          if (scl_rise_s && !full_q) begin
            shift_d = byte_nx;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BYTE_W - 1)) begin
              full_d = 1'b1;
              if (state_q == ADDR) begin
                if (byte_nx != addr_write_byte(DEV_ADDR)) begin
                  // Not addressed to us: drop out silently apart from the error strobe.
                  state_d    = IDLE;
                  full_d     = 1'b0;
                  rx_error_d = 1'b1;
                end
              end else if (state_q == BYTE1) begin
                hold_d.addr    = byte_nx[BYTE_W-1:1];
                hold_d.data[8] = byte_nx[0];
              end else begin
                hold_d.data[7:0] = byte_nx;
              end
            end
          end else if (scl_fall_s && full_q) begin
            full_d = 1'b0;
            cnt_d  = '0;
            ack_d  = 1'b1;
            case (state_q)
              ADDR:    state_d = ACK_A;
              BYTE1:   state_d = ACK_1;
              default: state_d = ACK_2;
            endcase
          end
        end
        ACK_A, ACK_1, ACK_2: begin
          if (scl_fall_s) begin
            ack_d = 1'b0;
            case (state_q)
              ACK_A:   state_d = BYTE1;
              ACK_1:   state_d = BYTE2;
              default: state_d = WAIT_STOP;
            endcase
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Scoreboard bench: stimulus queues expected write/error events, a monitor checks them as they appear.
module tb_i2c_codec_target;

  localparam int unsigned HALF = 20;

  typedef struct packed {
    logic       is_wr;
    logic [6:0] addr;
    logic [8:0] data;
  } exp_t;

  logic       clk   = 1'b0;
  logic       irstn = 1'b0;
  logic       scl   = 1'b1;
  logic       m_low = 1'b0;
  wire        sdat;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       wr_valid;
  logic       busy;
  logic       rx_error;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  pullup (sdat);
  assign sdat = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_codec_target dut (
    .clk     (clk),
    .irstn   (irstn),
    .SCLK    (scl),
    .SDAT    (sdat),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .wr_valid(wr_valid),
    .busy    (busy),
    .rx_error(rx_error)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every wr_valid / rx_error pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (irstn && (wr_valid || rx_error)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event actual wr_valid=%b rx_error=%b required none", wr_valid, rx_error);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind_wr", 16'(wr_valid), 16'(mon_e.is_wr));
        check("event_kind_err", 16'(rx_error), 16'(!mon_e.is_wr));
        if (mon_e.is_wr) begin
          check("commit_reg_addr", 16'(reg_addr), 16'(mon_e.addr));
          check("commit_reg_data", 16'(reg_data), 16'(mon_e.data));
        end
      end
    end
  end

  task automatic push_wr(input logic [6:0] a, input logic [8:0] d);
    exp_q.push_back('{is_wr: 1'b1, addr: a, data: d});
  endtask

  task automatic push_err();
    exp_q.push_back('{is_wr: 1'b0, addr: 7'h0, data: 9'h0});
  endtask

  task automatic hold();
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic start_cond();
    m_low = 1'b0; hold();
    scl   = 1'b1; hold();
    m_low = 1'b1; hold();
    scl   = 1'b0; hold();
  endtask

  task automatic stop_cond();
    m_low = 1'b1; hold();
    scl   = 1'b1; hold();
    m_low = 1'b0; hold();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; hold();
      scl   = 1'b1;  hold();
      scl   = 1'b0;  hold();
    end
  endtask

  task automatic ack_bit(input string name, input logic exp_sda);
    m_low = 1'b0; hold();
    scl   = 1'b1; hold();
    check(name, 16'(sdat), 16'(exp_sda));
    scl   = 1'b0; hold();
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sdat", 16'(sdat), 16'd1);
    check("rst_reg_addr", 16'(reg_addr), 16'd0);
    check("rst_reg_data", 16'(reg_data), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_wr_valid", 16'(wr_valid), 16'd0);
    check("rst_rx_error", 16'(rx_error), 16'd0);
    irstn = 1'b1;
    hold();
    check("idle_busy", 16'(busy), 16'd0);

    // Write 0x34,0x1E,0x00 -> reg 0x0F = 0x000.
    start_cond();
    check("t1_busy_after_start", 16'(busy), 16'd1);
    send_byte(8'h34); ack_bit("t1_ack_addr", 1'b0);
    send_byte(8'h1E); ack_bit("t1_ack_b1", 1'b0);
    send_byte(8'h00); ack_bit("t1_ack_b2", 1'b0);
    push_wr(7'h0F, 9'h000);
    stop_cond();
    check("t1_busy_after_stop", 16'(busy), 16'd0);
    check("t1_reg_addr", 16'(reg_addr), 16'h0F);
    check("t1_reg_data", 16'(reg_data), 16'h000);

    // Write 0x34,0x0D,0xFF with extra SCLK pulses before STOP -> reg 0x06 = 0x1FF.
    start_cond();
    send_byte(8'h34); ack_bit("t2_ack_addr", 1'b0);
    send_byte(8'h0D); ack_bit("t2_ack_b1", 1'b0);
    send_byte(8'hFF); ack_bit("t2_ack_b2", 1'b0);
    send_byte(8'hFF); ack_bit("t2_no_ack_wait_stop", 1'b1);
    push_wr(7'h06, 9'h1FF);
    stop_cond();
    check("t2_reg_addr", 16'(reg_addr), 16'h06);
    check("t2_reg_data", 16'(reg_data), 16'h1FF);

    // Wrong address 0x36: no ACK, error strobe, outputs untouched.
    push_err();
    start_cond();
    send_byte(8'h36); ack_bit("t3_nack_addr", 1'b1);
    stop_cond();
    check("t3_reg_addr_kept", 16'(reg_addr), 16'h06);
    check("t3_reg_data_kept", 16'(reg_data), 16'h1FF);
    check("t3_busy", 16'(busy), 16'd0);

    // Early STOP after first data byte aborts; a full write then succeeds.
    start_cond();
    send_byte(8'h34); ack_bit("t4_ack_addr", 1'b0);
    send_byte(8'h08); ack_bit("t4_ack_b1", 1'b0);
    push_err();
    stop_cond();
    check("t4_reg_addr_kept", 16'(reg_addr), 16'h06);
    check("t4_reg_data_kept", 16'(reg_data), 16'h1FF);
    check("t4_busy_after_abort", 16'(busy), 16'd0);
    start_cond();
    send_byte(8'h34); ack_bit("t4b_ack_addr", 1'b0);
    send_byte(8'h08); ack_bit("t4b_ack_b1", 1'b0);
    send_byte(8'h12); ack_bit("t4b_ack_b2", 1'b0);
    push_wr(7'h04, 9'h012);
    stop_cond();
    check("t4b_reg_addr", 16'(reg_addr), 16'h04);
    check("t4b_reg_data", 16'(reg_data), 16'h012);

    // Repeated START after the address byte, then a complete write.
    start_cond();
    send_byte(8'h34); ack_bit("t5_ack_addr", 1'b0);
    push_err();
    start_cond();
    check("t5_busy_after_rstart", 16'(busy), 16'd1);
    send_byte(8'h34); ack_bit("t5_ack_addr2", 1'b0);
    send_byte(8'h1E); ack_bit("t5_ack_b1", 1'b0);
    send_byte(8'h05); ack_bit("t5_ack_b2", 1'b0);
    push_wr(7'h0F, 9'h005);
    stop_cond();
    check("t5_reg_addr", 16'(reg_addr), 16'h0F);
    check("t5_reg_data", 16'(reg_data), 16'h005);

    // Reset while the target holds the second data byte ACK low.
    start_cond();
    send_byte(8'h34); ack_bit("t6_ack_addr", 1'b0);
    send_byte(8'h1E); ack_bit("t6_ack_b1", 1'b0);
    send_byte(8'h05);
    m_low = 1'b0;
    hold();
    check("t6_ack2_low", 16'(sdat), 16'd0);
    irstn = 1'b0;
    #1;
    check("t6_sdat_released", 16'(sdat), 16'd1);
    check("t6_reg_addr", 16'(reg_addr), 16'd0);
    check("t6_reg_data", 16'(reg_data), 16'd0);
    check("t6_busy", 16'(busy), 16'd0);
    check("t6_wr_valid", 16'(wr_valid), 16'd0);
    check("t6_rx_error", 16'(rx_error), 16'd0);
    repeat (5) @(posedge clk);
    #1;
    irstn = 1'b1;
    hold();
    stop_cond();
    check("t6_reg_addr_after", 16'(reg_addr), 16'd0);
    check("t6_busy_after", 16'(busy), 16'd0);

    hold();
    check("events_outstanding", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
